regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and write-back source encoding for the register-file write-back path.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between ALU and load write-back; grants are combinational (0 cycles).
// A lone requester wins immediately; on contention the source not granted last wins. No grants in reset.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  wb_src_t prio;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!rst) begin
      gnt_alu = req_alu && (!req_mem || prio == WB_SRC_ALU);
      gnt_mem = req_mem && (!req_alu || prio == WB_SRC_MEM);
    end
  end

  // Any grant hands priority to the other source, so contention alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= WB_SRC_ALU;
    end else if (gnt_alu) begin
      prio <= WB_SRC_MEM;
    end else if (gnt_mem) begin
      prio <= WB_SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load write-back into one register-file port (latency 1) and tracks pending writes.
// Readies are combinational from valids; a held request simply waits, and hazard stalls decode.
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  output logic                              alu_ready,
  input  logic                              mem_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]                   mem_data,
  output logic                              mem_ready,
  input  logic                              issue_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs2,
  output logic                              hazard,
  output logic [NREG-1:0]                   busy,
  output logic                              WE3,
  output logic [regfile_pkg::REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]                   WD3
);

  logic                              gnt_alu;
  logic                              gnt_mem;
  logic [regfile_pkg::REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]                   sel_data;
  logic [NREG-1:0]                   busy_nxt;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_valid),
    .req_mem (mem_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;
  assign sel_rd    = gnt_mem ? mem_rd   : alu_rd;
  assign sel_data  = gnt_mem ? mem_data : alu_data;

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (gnt_alu || gnt_mem) begin
      WE3 <= (sel_rd != '0);
      A3  <= sel_rd;
      WD3 <= sel_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  // Clear before set so a same-edge issue to the register being written stays pending.
  always_comb begin
    busy_nxt = busy;
    if (WE3) begin
      busy_nxt[A3] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign hazard = busy[rs1] | busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: behavioural model compared every cycle plus literal spot checks.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hazard, WE3;
  logic [31:0] busy;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .busy(busy), .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: who was granted last, the pending-write set, and the write expected on the port.
  bit          m_started = 0;
  bit          m_last_mem;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_pending [32];

  always @(posedge clk) begin
    bit ga, gm;
    if (rst) begin
      m_started  = 1;
      m_last_mem = 1;
      m_we = 0; m_a3 = 0; m_wd = 0;
      foreach (m_pending[i]) m_pending[i] = 0;
    end else if (m_started) begin
      ga = alu_valid && (!mem_valid || m_last_mem);
      gm = mem_valid && !ga;
      if (m_we) m_pending[m_a3] = 0;
      if (issue_valid && issue_rd != 0) m_pending[issue_rd] = 1;
      if (ga) begin
        m_we = (alu_rd != 0); m_a3 = alu_rd; m_wd = alu_data; m_last_mem = 0;
      end else if (gm) begin
        m_we = (mem_rd != 0); m_a3 = mem_rd; m_wd = mem_data; m_last_mem = 1;
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_busy;
    bit e_alu, e_mem;
    if (m_started) begin
      foreach (m_pending[i]) exp_busy[i] = m_pending[i];
      e_alu = !rst && alu_valid && (!mem_valid || m_last_mem);
      e_mem = !rst && mem_valid && !(alu_valid && (!mem_valid || m_last_mem));
      chk("model.alu_ready", 64'(alu_ready), 64'(e_alu));
      chk("model.mem_ready", 64'(mem_ready), 64'(e_mem));
      chk("model.busy", 64'(busy), 64'(exp_busy));
      chk("model.hazard", 64'(hazard), 64'(exp_busy[rs1] | exp_busy[rs2]));
      chk("model.WE3", 64'(WE3), 64'(m_we));
      if (m_we) begin
        chk("model.A3", 64'(A3), 64'(m_a3));
        chk("model.WD3", 64'(WD3), 64'(m_wd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask

  initial begin
    rst = 1; idle();
    alu_valid = 1; mem_valid = 1;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; mem_data = 0;
    tick(); tick();
    #1;
    chk("rst.alu_ready", 64'(alu_ready), 64'd0);
    chk("rst.mem_ready", 64'(mem_ready), 64'd0);
    chk("rst.WE3", 64'(WE3), 64'd0);
    chk("rst.A3", 64'(A3), 64'd0);
    chk("rst.WD3", 64'(WD3), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);

    // Lone ALU write to x5.
    rst = 0; idle();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("lone.alu_ready", 64'(alu_ready), 64'd1);
    tick(); idle();
    #1;
    chk("lone.WE3", 64'(WE3), 64'd1);
    chk("lone.A3", 64'(A3), 64'd5);
    chk("lone.WD3", 64'(WD3), 64'hDEADBEEF);
    tick();
    #1 chk("lone.WE3_drop", 64'(WE3), 64'd0);

    // Fresh reset, then four cycles of contention.
    rst = 1; tick(); rst = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h1111_0003;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h2222_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr.alu_ready", 64'(alu_ready), 64'(i % 2 == 0));
      chk("rr.mem_ready", 64'(mem_ready), 64'(i % 2 == 1));
      tick();
      chk("rr.WE3", 64'(WE3), 64'd1);
      chk("rr.A3", 64'(A3), (i % 2 == 0) ? 64'd3 : 64'd4);
    end
    idle();

    // Issue x7, load writes x7 two cycles later.
    issue_valid = 1; issue_rd = 7; rs1 = 7; rs2 = 0;
    tick(); idle();
    #1;
    chk("sb7.busy_set", 64'(busy[7]), 64'd1);
    chk("sb7.hazard_set", 64'(hazard), 64'd1);
    tick();
    mem_valid = 1; mem_rd = 7; mem_data = 32'h0000_0077;
    tick(); idle();
    #1;
    chk("sb7.WE3", 64'(WE3), 64'd1);
    chk("sb7.A3", 64'(A3), 64'd7);
    chk("sb7.busy_held", 64'(busy[7]), 64'd1);
    chk("sb7.hazard_held", 64'(hazard), 64'd1);
    tick();
    #1;
    chk("sb7.busy_clr", 64'(busy[7]), 64'd0);
    chk("sb7.hazard_clr", 64'(hazard), 64'd0);

    // Re-issue x9 on the edge its earlier write retires.
    issue_valid = 1; issue_rd = 9; rs1 = 9;
    tick(); idle();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick(); idle();
    issue_valid = 1; issue_rd = 9;
    #1 chk("sb9.WE3", 64'(WE3), 64'd1);
    tick(); idle();
    #1 chk("sb9.set_wins", 64'(busy[9]), 64'd1);
    tick();
    #1 chk("sb9.still", 64'(busy), 64'h0000_0200);

    // Writes and issues targeting x0.
    rs1 = 0;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    #1 chk("x0.mem_ready", 64'(mem_ready), 64'd1);
    tick(); idle();
    #1;
    chk("x0.WE3", 64'(WE3), 64'd0);
    chk("x0.busy0", 64'(busy[0]), 64'd0);
    issue_valid = 1; issue_rd = 0;
    tick(); idle();
    #1 chk("x0.busy_same", 64'(busy), 64'h0000_0200);

    // Reset right after an ALU acceptance.
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    tick(); idle();
    rst = 1; alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2;
    #1;
    chk("rstw.alu_ready", 64'(alu_ready), 64'd0);
    chk("rstw.mem_ready", 64'(mem_ready), 64'd0);
    tick();
    chk("rstw.WE3", 64'(WE3), 64'd0);
    chk("rstw.busy", 64'(busy), 64'd0);
    rst = 0;
    #1;
    chk("rstw.alu_first", 64'(alu_ready), 64'd1);
    chk("rstw.mem_wait", 64'(mem_ready), 64'd0);
    tick(); idle();
    #1 chk("rstw.A3", 64'(A3), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
